// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // Signed variants have a clear low opcode bit.
  function automatic logic is_signed(op_e op);
    return ~op[0];
  endfunction

  // Divides have the high opcode bit set.
  function automatic logic is_div(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_seq.sv
// Fixed-latency multi-cycle multiply/divide: shift-add multiply, restoring
// divide, magnitudes in the datapath with sign fix-up in a final cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e              state, state_n;
  logic                div_q, qsign, rsign, dz;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  acc;
  logic [WIDTH-1:0]    opnd, a_raw;

  logic                op_sgn, op_div, sa, sb, accept;
  logic [WIDTH-1:0]    mag_a, mag_b, quot_f, rem_f;
  logic [2*WIDTH-1:0]  prod_f, mul_nxt, div_nxt;
  logic [WIDTH:0]      msum, dtrial;

  assign op_sgn = is_signed(op_e'(op));
  assign op_div = is_div(op_e'(op));
  assign sa     = op_sgn & a[WIDTH-1];
  assign sb     = op_sgn & b[WIDTH-1];
  assign accept = (state == IDLE) && start && !cancel;

  muldiv_signfix #(.W(WIDTH)) u_abs_a (.neg(sa), .x(a), .y(mag_a));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (.neg(sb), .x(b), .y(mag_b));

  // Result fix-ups driven from the final accumulator and latched signs.
  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.neg(qsign), .x(acc), .y(prod_f));
  muldiv_signfix #(.W(WIDTH))   u_fix_quot (.neg(qsign), .x(acc[WIDTH-1:0]), .y(quot_f));
  muldiv_signfix #(.W(WIDTH))   u_fix_rem  (.neg(rsign), .x(acc[2*WIDTH-1:WIDTH]), .y(rem_f));

  // Multiply step: conditional add of the multiplicand into the upper half
  // (carry kept), then shift the whole accumulator right.
  assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_nxt = acc[0] ? {msum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // Divide step: trial-subtract the divisor from the shifted remainder; a
  // borrow means restore (keep the plain shift) and a zero quotient bit.
  assign dtrial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_nxt = dtrial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic; cancel aborts CALC/FIX but not DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !cancel) state_n = CALC;
      CALC:    if (cancel) state_n = IDLE;
               else if (cnt == '0) state_n = FIX;
      FIX:     state_n = cancel ? IDLE : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n == CALC) || (state_n == FIX);
      done <= (state_n == DONE);
    end
  end

  // Operand latch, iteration datapath and HI/LO commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= 1'b0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      a_raw <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          div_q <= op_div;
          qsign <= sa ^ sb;
          rsign <= sa;
          dz    <= op_div && (b == '0);
          opnd  <= op_div ? mag_b : mag_a;
          acc   <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
          a_raw <= a;
          cnt   <= CW'(WIDTH - 1);
        end
        CALC: if (!cancel) begin
          acc <= div_q ? div_nxt : mul_nxt;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: if (!cancel) begin
          if (!div_q) begin
            {hi, lo} <= prod_f;
          end else if (dz) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_f;
            lo <= quot_f;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: 32-bit and 8-bit instances.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start = 1'b0, cancel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, hi, lo;
  logic        busy, done;

  logic        start8 = 1'b0, cancel8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
  logic        busy8, done8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .cancel(cancel8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the chosen instance and wait (bounded) for done;
  // lat counts negedges after the accepting edge.
  task automatic run_op(input bit w8, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] h,
                        output logic [31:0] l, output int lat);
    @(negedge clk);
    if (w8) begin start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
    else    begin start  = 1'b1; op  = o; a  = x;      b  = y;      end
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    lat = 1;
    while (!(w8 ? done8 : done) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    h = w8 ? {24'b0, hi8} : hi;
    l = w8 ? {24'b0, lo8} : lo;
  endtask

  typedef struct {
    bit          w8;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] h, l;
    int lat, n;

    vecs[0] = '{1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[1] = '{1'b0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
    vecs[2] = '{1'b0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[3] = '{1'b0, 2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 34};
    vecs[4] = '{1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[5] = '{1'b0, 2'b10, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFE, 34};
    vecs[6] = '{1'b0, 2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34};
    vecs[7] = '{1'b1, 2'b01, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FE, 32'h0000_0001, 10};
    vecs[8] = '{1'b1, 2'b10, 32'h0000_0080, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0080, 10};
    vecs[9] = '{1'b1, 2'b00, 32'h0000_00FD, 32'h0000_0007, 32'h0000_00FF, 32'h0000_00EB, 10};

    // Reset state, observed before any clock edge has been released.
    #3;
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_hi",    hi,    32'h0);
    chk("rst_lo",    lo,    32'h0);
    chk("rst_hi8",   hi8,   8'h0);
    chk("rst_busy8", busy8, 1'b0);
    #9 rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, h, l, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_hi", i),  h,   vecs[i].hi);
      chk($sformatf("v%0d_lo", i),  l,   vecs[i].lo);
    end

    // Cancel at CALC cycle 10: no done, HI/LO keep the previous result,
    // and a fresh start is taken the very next cycle.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl_busy", busy, 1'b0);
    chk("cxl_done", done, 1'b0);
    chk("cxl_hi",   hi,   32'hFFFF_FFFB);
    chk("cxl_lo",   lo,   32'hFFFF_FFFF);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("cxl_restart_busy", busy, 1'b1);
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("cxl_restart_lat", lat, 34);
    chk("cxl_restart_lo",  lo,  32'd12);

    // start held through the whole operation yields a single done.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    start = 1'b0;
    chk("hold_lat", lat, 34);
    n = done ? 1 : 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("hold_ndone", n, 1);
    chk("hold_lo", lo, 32'd6);

    // Asynchronous reset mid-CALC clears outputs without a clock edge.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_hi",   hi,   32'h0);
    chk("arst_lo",   lo,   32'h0);
    #20 rst = 1'b1;

    // Unit is usable again after the abort.
    run_op(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7, h, l, lat);
    chk("post_lat", lat, 34);
    chk("post_hi",  h,   32'hFFFF_FFFF);
    chk("post_lo",  l,   32'hFFFF_FFEB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
